// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined 8x8 signed multiplier among NREQ requesters,
// with a tag pipeline that returns each product on a common response bus with its requester ID.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  input  logic                 hold,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_p,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_p,
  output logic [2:0]           inflight,
  output logic                 busy
);
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    grant;
  logic              found, xfer;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [7:0]        last_a_q, last_a_d, last_b_q, last_b_d;
  logic [MUL_LAT-1:0] tv_q, tv_d;
  logic [IDW-1:0]    tid_q [MUL_LAT];
  logic [IDW-1:0]    tid_d [MUL_LAT];
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [15:0]       rsp_p_q, rsp_p_d;
  logic [2:0]        cnt;

  // Rotate the request vector so bit 0 is the requester at rr_ptr; lowest set bit wins.
  always_comb begin
    dbl   = {req_valid, req_valid} >> rr_ptr_q;
    rot   = dbl[NREQ-1:0];
    grant = '0;
    found = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        grant = IDW'((int'(rr_ptr_q) + k) % NREQ);
        found = 1'b1;
      end
    end
    xfer      = found & ~hold & ~rst;
    req_ready = xfer ? NREQ'(1) << grant : '0;
    mul_a     = xfer ? 8'(req_a >> {grant, 3'b000}) : last_a_q;
    mul_b     = xfer ? 8'(req_b >> {grant, 3'b000}) : last_b_q;
    last_a_d  = mul_a;
    last_b_d  = mul_b;
    rr_ptr_d  = !xfer ? rr_ptr_q : (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
  end

  always_comb begin
    tv_d     = {tv_q[MUL_LAT-2:0], xfer};
    tid_d[0] = grant;
    for (int i = 1; i < MUL_LAT; i++) tid_d[i] = tid_q[i-1];
    rsp_valid_d = tv_q[MUL_LAT-1];
    rsp_id_d    = tv_q[MUL_LAT-1] ? tid_q[MUL_LAT-1] : rsp_id_q;
    rsp_p_d     = tv_q[MUL_LAT-1] ? mul_p : rsp_p_q;
    cnt = '0;
    for (int i = 0; i < MUL_LAT; i++) cnt = cnt + 3'(tv_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      last_a_q    <= '0;
      last_b_q    <= '0;
      tv_q        <= '0;
      tid_q       <= '{default: '0};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      last_a_q    <= last_a_d;
      last_b_q    <= last_b_d;
      tv_q        <= tv_d;
      tid_q       <= tid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign inflight  = cnt;
  assign busy      = (cnt != 3'd0) | rsp_valid_q;
endmodule
